// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared state encoding and load-window defaults for boot_loader
package boot_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        LOAD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_t;

    localparam logic [7:0] PROG_BASE_DEF = 8'h00;
    localparam int         LOAD_MAX_DEF  = 128;

endpackage

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - holds the CPU in reset, streams an image into memory, then hands the bus over
module boot_loader
    import boot_pkg::*;
#(
    parameter logic [7:0] PROG_BASE = PROG_BASE_DEF,
    parameter int         LOAD_MAX  = LOAD_MAX_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] len,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] cpu_address,
    input  logic [7:0] cpu_to_memory,
    input  logic       cpu_write,
    output logic [7:0] mem_address,
    output logic [7:0] mem_to_memory,
    output logic       mem_write,
    output logic       cpu_reset,
    output logic       busy,
    output logic       done,
    output logic       err
);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] len_q, len_d;
    logic       err_q, err_d;
    logic       len_ok;
    logic       beat;

    // 9-bit compare so a LOAD_MAX of 256 does not wrap to zero.
    assign len_ok = (len != 8'd0) && ({1'b0, len} <= 9'(LOAD_MAX));
    assign beat   = (state_q == LOAD) && in_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= HOLD;
            cnt_q   <= 8'd0;
            len_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        err_d   = err_q;
        case (state_q)
            HOLD, RUN: begin
                if (start) begin
                    if (len_ok) begin
                        state_d = LOAD;
                        len_d   = len;
                        cnt_d   = 8'd0;
                        err_d   = 1'b0;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (beat) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == len_q - 8'd1) begin
                        state_d = RELEASE;
                    end
                end
            end
            RELEASE: state_d = RUN;
            default: state_d = HOLD;
        endcase
    end

    // Bus mux: the loader owns memory until RUN, then the CPU passes straight through.
    always_comb begin
        mem_address   = PROG_BASE;
        mem_to_memory = 8'd0;
        mem_write     = 1'b0;
        case (state_q)
            LOAD: begin
                mem_address = PROG_BASE + cnt_q;
                if (beat) begin
                    mem_to_memory = in_data;
                    mem_write     = 1'b1;
                end
            end
            RUN: begin
                mem_address   = cpu_address;
                mem_to_memory = cpu_to_memory;
                mem_write     = cpu_write;
            end
            default: ;
        endcase
    end

    assign in_ready  = (state_q == LOAD);
    assign busy      = (state_q == LOAD) || (state_q == RELEASE);
    assign done      = (state_q == RELEASE);
    assign cpu_reset = (state_q == RUN);
    assign err       = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - scoreboard bench for boot_loader load, error, pass-through and reset scenarios
module tb_boot_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] len = 8'd0;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] cpu_address = 8'd0;
    logic [7:0] cpu_to_memory = 8'd0;
    logic       cpu_write = 1'b0;
    logic [7:0] mem_address;
    logic [7:0] mem_to_memory;
    logic       mem_write;
    logic       cpu_reset;
    logic       busy;
    logic       done;
    logic       err;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    logic [7:0] exp_addr;
    logic [15:0] sb[$];

    boot_loader dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .len           (len),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .cpu_address   (cpu_address),
        .cpu_to_memory (cpu_to_memory),
        .cpu_write     (cpu_write),
        .mem_address   (mem_address),
        .mem_to_memory (mem_to_memory),
        .mem_write     (mem_write),
        .cpu_reset     (cpu_reset),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    // Loader-owned writes (CPU held in reset) are popped against the scoreboard.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (mem_write && !cpu_reset) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got addr=%02h data=%02h, required no write", mem_address, mem_to_memory);
            end else begin
                logic [15:0] e;
                e = sb.pop_front();
                if ({mem_address, mem_to_memory} !== e) begin
                    n_err++;
                    $display("FAIL write: got addr=%02h data=%02h, required addr=%02h data=%02h",
                             mem_address, mem_to_memory, e[15:8], e[7:0]);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        cpu_write = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic do_start(input logic [7:0] l);
        start = 1'b1;
        len = l;
        next_cycle();
        start = 1'b0;
        len = 8'd0;
        exp_addr = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        in_valid = 1'b1;
        in_data = b;
        sb.push_back({exp_addr, b});
        exp_addr = exp_addr + 8'd1;
        next_cycle();
        in_valid = 1'b0;
        in_data = 8'h00;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b1) begin
                n_err++;
                $display("FAIL busy_gap: got %b, required 1", busy);
            end
            next_cycle();
        end
    endtask

    task automatic check_release();
        @(negedge clk);
        n_cmp++;
        if ({done, busy, cpu_reset, mem_write} !== 4'b1100) begin
            n_err++;
            $display("FAIL release: got done/busy/cpu_reset/wr=%b, required 1100", {done, busy, cpu_reset, mem_write});
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if ({done, busy, cpu_reset} !== 3'b001) begin
            n_err++;
            $display("FAIL run_entry: got done/busy/cpu_reset=%b, required 001", {done, busy, cpu_reset});
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d pending writes, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({in_ready, mem_address, mem_to_memory, mem_write, cpu_reset, busy, done, err} !== 22'd0) begin
            n_err++;
            $display("FAIL reset_vals: got rdy=%b a=%02h d=%02h w=%b cr=%b b=%b dn=%b e=%b, required all 0",
                     in_ready, mem_address, mem_to_memory, mem_write, cpu_reset, busy, done, err);
        end
        apply_reset();
        @(negedge clk);
        n_cmp++;
        if ({in_ready, cpu_reset, busy, err} !== 4'b0000) begin
            n_err++;
            $display("FAIL hold_idle: got %b, required 0000", {in_ready, cpu_reset, busy, err});
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        do_start(8'd3);
        @(negedge clk);
        n_cmp++;
        if ({in_ready, busy, cpu_reset} !== 3'b110) begin
            n_err++;
            $display("FAIL load_entry: got rdy/busy/cr=%b, required 110", {in_ready, busy, cpu_reset});
        end
        next_cycle();
        send_byte(8'hA1, 0);
        send_byte(8'hB2, 0);
        send_byte(8'hC3, 0);
        check_release();
    endtask

    task automatic test_gaps();
        apply_reset();
        do_start(8'd3);
        send_byte(8'hA1, 2);
        send_byte(8'hB2, 2);
        send_byte(8'hC3, 0);
        check_release();
    endtask

    task automatic test_err();
        apply_reset();
        do_start(8'd0);
        @(negedge clk);
        n_cmp++;
        if ({err, busy, cpu_reset} !== 3'b100) begin
            n_err++;
            $display("FAIL err_len0: got err/busy/cr=%b, required 100", {err, busy, cpu_reset});
        end
        next_cycle();
        do_start(8'd200);
        @(negedge clk);
        n_cmp++;
        if ({err, busy, in_ready} !== 3'b100) begin
            n_err++;
            $display("FAIL err_len200: got err/busy/rdy=%b, required 100", {err, busy, in_ready});
        end
        next_cycle();
        do_start(8'd129);
        @(negedge clk);
        n_cmp++;
        if ({err, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL err_len129: got err/busy=%b, required 10", {err, busy});
        end
        next_cycle();
        do_start(8'd1);
        @(negedge clk);
        n_cmp++;
        if ({err, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL err_clear: got err/rdy=%b, required 01", {err, in_ready});
        end
        send_byte(8'h77, 0);
        check_release();
    endtask

    task automatic test_passthrough();
        cpu_address = 8'h80;
        cpu_to_memory = 8'h5A;
        cpu_write = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({mem_address, mem_to_memory, mem_write} !== {8'h80, 8'h5A, 1'b1}) begin
            n_err++;
            $display("FAIL passthru: got a=%02h d=%02h w=%b, required 80 5a 1", mem_address, mem_to_memory, mem_write);
        end
        next_cycle();
        start = 1'b1;
        len = 8'd2;
        @(negedge clk);
        n_cmp++;
        if ({mem_address, mem_write, cpu_reset} !== {8'h80, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL passthru_start: got a=%02h w=%b cr=%b, required 80 1 1", mem_address, mem_write, cpu_reset);
        end
        next_cycle();
        start = 1'b0;
        exp_addr = 8'h00;
        @(negedge clk);
        n_cmp++;
        if ({cpu_reset, mem_write, in_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL reload_entry: got cr/w/rdy=%b, required 001", {cpu_reset, mem_write, in_ready});
        end
        next_cycle();
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        cpu_write = 1'b0;
        check_release();
    endtask

    task automatic test_reset_mid();
        int d0;
        apply_reset();
        d0 = done_cnt;
        do_start(8'd5);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        in_valid = 1'b1;
        in_data = 8'h03;
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({cpu_reset, in_ready, busy, mem_write} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_mid: got cr/rdy/busy/w=%b, required 0000", {cpu_reset, in_ready, busy, mem_write});
        end
        next_cycle();
        reset = 1'b1;
        repeat (6) next_cycle();
        in_valid = 1'b0;
        n_cmp++;
        if (done_cnt != d0) begin
            n_err++;
            $display("FAIL reset_no_done: got %0d pulses, required 0", done_cnt - d0);
        end
        n_cmp++;
        if ({busy, cpu_reset} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_hold: got busy/cr=%b, required 00", {busy, cpu_reset});
        end
    endtask

    task automatic test_start_in_load();
        do_start(8'd3);
        send_byte(8'hD1, 0);
        start = 1'b1;
        len = 8'd1;
        send_byte(8'hD2, 0);
        len = 8'd0;
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, err} !== 3'b100) begin
            n_err++;
            $display("FAIL start_ignored: got busy/done/err=%b, required 100", {busy, done, err});
        end
        send_byte(8'hD3, 0);
        check_release();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_err();
        test_passthrough();
        test_reset_mid();
        test_start_in_load();
        repeat (2) next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, required finish");
        $fatal(1);
    end

endmodule
